ad53xx_multi_dac_ctrl: RTL
==========================

Name: ad53xx_multi_dac_ctrl

Overview:
Parametrised multi-channel controller for AD53xx-family serial DACs that share one DCLK/DIN/LDAC bus, with one SYNC per channel. It decodes 32-bit address/data commands from the UART command path and serialises each data word to the addressed channel with its own SPI engine. It adds a one-deep pending command buffer, a broadcast LDAC command and a selectable LDAC mode.

Parameters:
NUM_CH, 2, number of DAC channels / SYNC lines (1..8)
DATA_BITS, 16, bits per SPI frame, sent MSB first (8..16)
ADDR_BASE, 16'hdac0, command address of channel 0; channel k is at ADDR_BASE+k
LDAC_ADDR, 16'hdacf, broadcast LDAC command address; must lie outside ADDR_BASE..ADDR_BASE+NUM_CH-1
CLK_DIV, 10, clk cycles per DCLK half-period (>=2)
LDAC_MODE, 0, 0 = pulse LDAC after every write; 1 = pulse LDAC only on a LDAC_ADDR command
LDAC_CYCLES, 10, width of the LDAC low pulse in clk cycles (>=1)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
cmd_data  in  32  [31:16] address, [DATA_BITS-1:0] data word
cmd_valid  in  1  one-cycle command strobe
cmd_busy  out  1  high while a frame or LDAC pulse is in progress, or a command is pending
cmd_drop  out  1  one-cycle pulse when a valid command is discarded because the buffer is full
done  out  1  one-cycle pulse at the end of each command (frame or LDAC)
sync_n  out  NUM_CH  per-channel active-low frame select
dclk  out  1  shared serial clock, idle low
din  out  1  shared serial data
ldac_n  out  1  active-low shared DAC update

Behaviour:
- Reset values: sync_n all 1, dclk 0, din 0, ldac_n 1, cmd_busy 0, cmd_drop 0, done 0. FSM is IDLE, pending buffer is empty.
- Reset mid-frame aborts the frame immediately. All outputs return to reset values asynchronously.
- Decode: address == ADDR_BASE+k with k<NUM_CH gives a WRITE to channel k. Address == LDAC_ADDR gives an LDAC command. Any other address is ignored: no busy, no drop.
- Buffer: a decoded command is accepted into the pending slot when the slot is empty.
  - If the FSM is IDLE with an empty slot, the command goes to the FSM directly on the next edge.
  - If the slot is full, the command is dropped and cmd_drop pulses.
  - A command arriving in the same cycle that the FSM pops the slot is accepted.
- FSM states and transitions:
  - IDLE: start when a command is pending or directly presented. WRITE goes to SETUP; LDAC goes to LDAC.
  - SETUP: sync_n[k]=0, din=MSB, dclk=0 for CLK_DIV cycles, then SHIFT.
  - SHIFT: per bit, dclk is high for CLK_DIV cycles, then low for CLK_DIV cycles. din changes on the dclk rising edge, except the first bit, which is set in SETUP. The DAC samples on the falling edge. Bit counter runs DATA_BITS-1 down to 0.
  - SHIFT exit: after the last falling edge, sync_n[k] holds low 1 further cycle, then goes HOLD.
  - HOLD: all sync_n=1, din=0 for CLK_DIV cycles. Then go to LDAC if LDAC_MODE=0, else DONE.
  - LDAC: ldac_n=0 for exactly LDAC_CYCLES cycles, then DONE.
  - DONE: done=1 for one cycle, then IDLE.
- Frame timing: sync_n is low for CLK_DIV + 2*CLK_DIV*DATA_BITS + 1 cycles. With the defaults that is 331 cycles.
- WRITE in LDAC_MODE=1 only loads the input register. An LDAC command then updates all channels together.
- LDAC command in LDAC_MODE=0 still produces one pulse, with no frame.
- Only one sync_n bit is ever low at a time. ldac_n is never low while any sync_n is low.
- Back-to-back: a pending command starts in the cycle after DONE. The minimum IDLE dwell is 1 cycle.

Test Plan:
1. Reset, then cmd 32'hdac1_a5c3 (defaults) -> sync_n=2'b01 for 331 cycles. Bits 1010_0101_1100_0011 are sampled on 16 dclk falls, each dclk half-period is 10 cycles. ldac_n is low for 10 cycles after HOLD, then done pulses once.
2. LDAC_MODE=1: write 32'hdac0_1234, then 32'hdacf_0000 -> no ldac_n pulse after the frame. One 10-cycle ldac_n pulse follows the second command, with sync_n all 1 throughout.
3. Three valid commands on consecutive cycles during a frame -> second is buffered and executed right after DONE. Third is dropped: cmd_drop pulses once, and done pulses twice in total.
4. cmd 32'hdac5_ffff with NUM_CH=2, and 32'h1234_0000 -> no activity, cmd_busy stays 0, cmd_drop stays 0.
5. Assert rst_n low mid-SHIFT (bit 7) -> sync_n, dclk, din, ldac_n and cmd_busy return to reset values immediately. The next command produces a full, clean frame.
6. NUM_CH=4, DATA_BITS=12, CLK_DIV=2: write channel 3 with 12'h8F1 -> sync_n=4'b0111 low for 51 cycles, 12 falling edges.

Source files
------------

// File: rtl/ad53xx_multi_dac_ctrl_if.sv
// Command bus between the UART command decoder and the multi-channel DAC
// controller.
//   cmd_data  : [31:16] address, [15:0] data word
//   cmd_valid : one-cycle command strobe
//   cmd_busy  : controller is executing or holding a pending command
//   cmd_drop  : one-cycle pulse, a decoded command was discarded
//   done      : one-cycle pulse at the end of each executed command
interface ad53xx_multi_dac_ctrl_if;
   logic [31:0] cmd_data;
   logic        cmd_valid;
   logic        cmd_busy;
   logic        cmd_drop;
   logic        done;

   modport master (output cmd_data, output cmd_valid,
                   input  cmd_busy, input  cmd_drop, input done);
   modport slave  (input  cmd_data, input  cmd_valid,
                   output cmd_busy, output cmd_drop, output done);
endinterface

// File: rtl/ad53xx_multi_dac_ctrl.sv
// Multi-channel AD53xx DAC controller. Decodes address/data commands,
// keeps a one-deep pending slot, and serialises each word MSB first on the
// shared dclk/din bus with a per-channel sync_n. ldac_n is pulsed after each
// write (LDAC_MODE=0) or only on a broadcast LDAC command (LDAC_MODE=1).
//   clk, rst_n : system clock, asynchronous active-low reset
//   cmd        : command bus (slave side)
//   sync_n     : per-channel active-low frame select
//   dclk, din  : shared serial clock (idle low) and data
//   ldac_n     : shared active-low DAC update
//
// state   | meaning
// --------+--------------------------------------------------------
// S_IDLE  | waiting for a pending or directly presented command
// S_SETUP | sync_n[ch] low, din = MSB, dclk low for CLK_DIV cycles
// S_SHIFT | dclk high CLK_DIV, low CLK_DIV per bit, DATA_BITS bits
// S_TAIL  | one extra cycle with sync_n[ch] low after the last fall
// S_HOLD  | all sync_n high, din low for CLK_DIV cycles
// S_LDAC  | ldac_n low for LDAC_CYCLES cycles
// S_DONE  | done pulse, back to S_IDLE
module ad53xx_multi_dac_ctrl #(
   parameter int          NUM_CH      = 2,
   parameter int          DATA_BITS   = 16,
   parameter logic [15:0] ADDR_BASE   = 16'hdac0,
   parameter logic [15:0] LDAC_ADDR   = 16'hdacf,
   parameter int          CLK_DIV     = 10,
   parameter int          LDAC_MODE   = 0,
   parameter int          LDAC_CYCLES = 10
) (
   input  logic                         clk,
   input  logic                         rst_n,
   ad53xx_multi_dac_ctrl_if.slave       cmd,
   output logic [NUM_CH-1:0]            sync_n,
   output logic                         dclk,
   output logic                         din,
   output logic                         ldac_n
);
   localparam int TMAX = (CLK_DIV > LDAC_CYCLES) ? CLK_DIV : LDAC_CYCLES;
   localparam int TW   = $clog2(TMAX + 1);
   localparam int BW   = $clog2(DATA_BITS);
   localparam int CHW  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

   typedef enum logic [2:0] {
      S_IDLE, S_SETUP, S_SHIFT, S_TAIL, S_HOLD, S_LDAC, S_DONE
   } state_t;

   state_t                state, state_nxt;
   logic [TW-1:0]         tmr;
   logic [BW-1:0]         bit_cnt;
   logic                  hi;
   logic [DATA_BITS-1:0]  sreg;
   logic [CHW-1:0]        ch;

   logic                  pend_valid, pend_ld;
   logic [CHW-1:0]        pend_ch;
   logic [DATA_BITS-1:0]  pend_word;
   logic                  drop_q;

   logic [15:0]           addr, offs;
   logic                  is_wr, is_ld, dec_valid;
   logic                  idle, direct, pop, accept, start_valid, st_ld;
   logic [CHW-1:0]        st_ch;
   logic [DATA_BITS-1:0]  st_word;
   logic                  tc, in_frame;

   assign addr      = cmd.cmd_data[31:16];
   assign offs      = addr - ADDR_BASE;
   assign is_wr     = (offs < 16'(NUM_CH));
   assign is_ld     = (addr == LDAC_ADDR);
   assign dec_valid = cmd.cmd_valid && (is_wr || is_ld);

   assign idle   = (state == S_IDLE);
   assign direct = idle && !pend_valid && dec_valid;
   assign pop    = idle && pend_valid;
   // the slot frees in the cycle it is popped, so a command arriving then still fits
   assign accept = dec_valid && !direct && (!pend_valid || pop);

   assign start_valid = pop || direct;
   assign st_ld       = pend_valid ? pend_ld   : is_ld;
   assign st_ch       = pend_valid ? pend_ch   : offs[CHW-1:0];
   assign st_word     = pend_valid ? pend_word : cmd.cmd_data[DATA_BITS-1:0];

   assign tc = (tmr == '0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pend_valid <= 1'b0;
         pend_ld    <= 1'b0;
         pend_ch    <= '0;
         pend_word  <= '0;
         drop_q     <= 1'b0;
      end else begin
         pend_valid <= accept || (pend_valid && !pop);
         drop_q     <= dec_valid && pend_valid && !pop;
         if (accept) begin
            pend_ld   <= is_ld;
            pend_ch   <= offs[CHW-1:0];
            pend_word <= cmd.cmd_data[DATA_BITS-1:0];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (start_valid) state_nxt = st_ld ? S_LDAC : S_SETUP;
         S_SETUP: if (tc) state_nxt = S_SHIFT;
         S_SHIFT: if (tc && !hi && bit_cnt == '0) state_nxt = S_TAIL;
         S_TAIL:  state_nxt = S_HOLD;
         S_HOLD:  if (tc) state_nxt = (LDAC_MODE == 0) ? S_LDAC : S_DONE;
         S_LDAC:  if (tc) state_nxt = S_DONE;
         S_DONE:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tmr     <= '0;
         bit_cnt <= '0;
         hi      <= 1'b0;
         sreg    <= '0;
         ch      <= '0;
      end else begin
         case (state)
            S_IDLE: if (start_valid) begin
               tmr  <= st_ld ? TW'(LDAC_CYCLES - 1) : TW'(CLK_DIV - 1);
               sreg <= st_word;
               ch   <= st_ch;
            end
            S_SETUP: if (tc) begin
               tmr     <= TW'(CLK_DIV - 1);
               hi      <= 1'b1;
               bit_cnt <= BW'(DATA_BITS - 1);
            end else tmr <= tmr - 1'b1;
            S_SHIFT: if (!tc) tmr <= tmr - 1'b1;
            else if (hi) begin
               hi  <= 1'b0;
               tmr <= TW'(CLK_DIV - 1);
            end else if (bit_cnt != '0) begin
               // next bit appears on din together with the dclk rise
               hi      <= 1'b1;
               bit_cnt <= bit_cnt - 1'b1;
               sreg    <= {sreg[DATA_BITS-2:0], 1'b0};
               tmr     <= TW'(CLK_DIV - 1);
            end
            S_TAIL: tmr <= TW'(CLK_DIV - 1);
            S_HOLD: if (tc) tmr <= TW'(LDAC_CYCLES - 1);
                    else    tmr <= tmr - 1'b1;
            S_LDAC: if (!tc) tmr <= tmr - 1'b1;
            default: ;
         endcase
      end
   end

   assign in_frame = (state == S_SETUP) || (state == S_SHIFT) || (state == S_TAIL);

   always_comb begin
      sync_n = '1;
      if (in_frame) sync_n[ch] = 1'b0;
   end

   assign dclk         = (state == S_SHIFT) && hi;
   assign din          = in_frame && sreg[DATA_BITS-1];
   assign ldac_n       = (state != S_LDAC);
   assign cmd.done     = (state == S_DONE);
   assign cmd.cmd_busy = !idle || pend_valid;
   assign cmd.cmd_drop = drop_q;
endmodule
